sum_accumulator: RTL and testbench



---
 rtl/sum_accumulator_if.sv | 42 ++++
 rtl/sum_accumulator.sv | 109 ++++++++++
 tb/tb_sum_accumulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an operand/result producer-consumer and the
// sum accumulator. The master side drives operands and takes results,
// the slave side is the accumulator itself.
interface sum_accumulator_if #(
    parameter int WIDTH = 6
);
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_overflow;
    logic             busy;

    // Driver/consumer side of the accumulator
    modport master (
        output start,
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_overflow,
        input  busy
    );

    // Accumulator side
    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_overflow,
        output busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Multi-operand summing stage: adds COUNT operands into a running WIDTH-bit
// accumulator through a ripple chain of full-adder cells, then presents the
// total and a sticky overflow flag on a registered valid/ready result port.
module sum_accumulator #(
    parameter int WIDTH = 6,
    parameter int COUNT = 4
) (
    input logic               clk,
    input logic               rst,
    sum_accumulator_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] LAST_CNT = 4'(COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sumOut_q, sumOut_d;
    logic             ovfOut_q, ovfOut_d;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sumBits;
    logic             ovfNext;

    // Ripple chain of full-adder cells: acc + in_data with carry-in tied low,
    // the final carry-out reports that the true sum left the WIDTH-bit range.
    assign carry[0] = 1'b0;
    for (genvar g = 0; g < WIDTH; g++) begin : g_fullAdder
        assign sumBits[g]   = acc_q[g] ^ bus.in_data[g] ^ carry[g];
        assign carry[g + 1] = (acc_q[g] & bus.in_data[g])
                            | (carry[g] & (acc_q[g] ^ bus.in_data[g]));
    end

    assign ovfNext = ovf_q | carry[WIDTH];

    // Next-state logic: start clears the batch in IDLE, every accepted operand
    // is folded into acc, and the COUNT-th one also snapshots the result into
    // the output registers so they hold it through DONE and the following IDLE.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        sumOut_d = sumOut_q;
        ovfOut_d = ovfOut_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = sumBits;
                    ovf_d = ovfNext;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DONE;
                        sumOut_d = sumBits;
                        ovfOut_d = ovfNext;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces everything, including the
    // held result, back to zero at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sumOut_q <= '0;
            ovfOut_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            sumOut_q <= sumOut_d;
            ovfOut_q <= ovfOut_d;
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.busy         = (state_q == ACCUM) || (state_q == DONE);
    assign bus.out_sum      = sumOut_q;
    assign bus.out_overflow = ovfOut_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: a table of batches with their
// expected totals, a few random batches checked against a small model, and
// hand-written sequences for backpressure and reset in the middle of a batch.
module tb_sum_accumulator;

    localparam int WIDTH = 6;
    localparam int COUNT = 4;

    typedef struct {
        logic [3:0][WIDTH-1:0] ops;
        int                    gap;
        bit                    startInGap;
        int                    hold;
        bit                    startInHold;
        logic [WIDTH-1:0]      expSum;
        logic                  expOvf;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;

    int   vecCount  = 0;
    int   missCount = 0;
    exp_t expQ[$];
    vec_t vecs[6];

    sum_accumulator_if #(.WIDTH(WIDTH)) bus ();

    sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0][WIDTH-1:0] pack4(input int a, input int b,
                                                    input int c, input int d);
        logic [3:0][WIDTH-1:0] p;
        p[0] = WIDTH'(a);
        p[1] = WIDTH'(b);
        p[2] = WIDTH'(c);
        p[3] = WIDTH'(d);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a batch and feed its operands, with optional idle cycles between
    // operands (and an optional start pulse during them, which must be ignored).
    // Measures edges from the start edge until out_valid is first seen.
    task automatic applyStimulus(input logic [3:0][WIDTH-1:0] ops, input int gap,
                                 input bit startInGap);
        int edges;
        int seenAt;
        int expLatency;
        edges  = 0;
        seenAt = -1;
        expLatency = 1 + COUNT + gap * (COUNT - 1);
        bus.start = 1'b1;
        tick();
        edges++;
        bus.start = 1'b0;
        check("in_ready after start", bus.in_ready, 1'b1);
        check("busy after start", bus.busy, 1'b1);
        for (int i = 0; i < COUNT; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = ops[i];
            tick();
            edges++;
            if (seenAt < 0 && bus.out_valid === 1'b1) seenAt = edges;
            bus.in_valid = 1'b0;
            if (i < COUNT - 1) begin
                for (int k = 0; k < gap; k++) begin
                    bus.start = startInGap;
                    bus.in_data = WIDTH'($urandom_range(0, 63));
                    tick();
                    edges++;
                    if (seenAt < 0 && bus.out_valid === 1'b1) seenAt = edges;
                    check("in_ready during gap", bus.in_ready, 1'b1);
                end
                bus.start = 1'b0;
            end
        end
        for (int w = 0; w < 10 && seenAt < 0; w++) begin
            tick();
            edges++;
            if (bus.out_valid === 1'b1) seenAt = edges;
        end
        if (seenAt < 0) begin
            $display("[TB] FAIL out_valid timeout: got none within %0d edges, expected at %0d",
                     edges, expLatency);
            vecCount++;
            missCount++;
        end else begin
            check("result latency", seenAt, expLatency);
        end
    endtask

    // Pop the expected result, compare it, hold out_ready low for a few cycles
    // (optionally pulsing start) and then complete the result handshake.
    task automatic checkOutput(input int hold, input bit startInHold);
        exp_t e;
        if (expQ.size() == 0) begin
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            vecCount++;
            missCount++;
            return;
        end
        e = expQ.pop_front();
        check("out_valid", bus.out_valid, 1'b1);
        check("out_sum", bus.out_sum, e.sum);
        check("out_overflow", bus.out_overflow, e.ovf);
        check("in_ready in DONE", bus.in_ready, 1'b0);
        for (int h = 0; h < hold; h++) begin
            bus.out_ready = 1'b0;
            bus.start = startInHold;
            tick();
            check("held out_valid", bus.out_valid, 1'b1);
            check("held out_sum", bus.out_sum, e.sum);
            check("held out_overflow", bus.out_overflow, e.ovf);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid after handshake", bus.out_valid, 1'b0);
        check("busy after handshake", bus.busy, 1'b0);
        check("out_sum kept in IDLE", bus.out_sum, e.sum);
        tick();
        check("stays IDLE", bus.busy, 1'b0);
    endtask

    initial begin
        logic [3:0][WIDTH-1:0] rops;
        exp_t                  m;
        logic [WIDTH:0]        acc;

        vecs[0] = '{pack4(3, 1, 2, 5),    0, 1'b0, 0, 1'b0, 6'd11, 1'b0};
        vecs[1] = '{pack4(40, 30, 0, 0),  0, 1'b0, 0, 1'b0, 6'd6,  1'b1};
        vecs[2] = '{pack4(1, 1, 1, 1),    0, 1'b0, 0, 1'b0, 6'd4,  1'b0};
        vecs[3] = '{pack4(63, 1, 63, 1),  0, 1'b0, 0, 1'b0, 6'd0,  1'b1};
        vecs[4] = '{pack4(10, 20, 5, 2),  0, 1'b0, 3, 1'b1, 6'd37, 1'b0};
        vecs[5] = '{pack4(7, 8, 9, 10),   2, 1'b1, 0, 1'b0, 6'd34, 1'b0};

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset in_ready", bus.in_ready, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset out_sum", bus.out_sum, 6'd0);
        check("reset out_overflow", bus.out_overflow, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            expQ.push_back('{vecs[i].expSum, vecs[i].expOvf});
            applyStimulus(vecs[i].ops, vecs[i].gap, vecs[i].startInGap);
            checkOutput(vecs[i].hold, vecs[i].startInHold);
        end

        // Random batches checked against a wide-sum model with sticky carry
        for (int r = 0; r < 4; r++) begin
            acc   = '0;
            m.ovf = 1'b0;
            for (int i = 0; i < COUNT; i++) begin
                rops[i] = WIDTH'($urandom_range(0, 63));
                acc = {1'b0, acc[WIDTH-1:0]} + {1'b0, rops[i]};
                if (acc[WIDTH]) m.ovf = 1'b1;
            end
            m.sum = acc[WIDTH-1:0];
            expQ.push_back(m);
            applyStimulus(rops, r % 2, 1'b0);
            checkOutput(1, 1'b0);
        end

        // Reset after two of four operands, then a clean batch
        expQ.push_back('{6'd7, 1'b0});
        applyStimulus(pack4(3, 4, 0, 0), 0, 1'b0);
        checkOutput(0, 1'b0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 6'd5;
        tick();
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("mid-batch reset out_valid", bus.out_valid, 1'b0);
        check("mid-batch reset in_ready", bus.in_ready, 1'b0);
        check("mid-batch reset busy", bus.busy, 1'b0);
        check("mid-batch reset out_sum", bus.out_sum, 6'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle after reset release", bus.in_ready, 1'b0);
        expQ.push_back('{6'd8, 1'b0});
        applyStimulus(pack4(2, 2, 2, 2), 0, 1'b0);
        checkOutput(0, 1'b0);

        if (expQ.size() != 0) begin
            $display("[TB] FAIL scoreboard drain: got %0d left, expected 0", expQ.size());
            vecCount++;
            missCount++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
